bc_scan: RTL
============

BC_SCAN -- requirements
Module: bc_scan

Interface
REQ-001 Parameter BOX_IDX, default 3, meaning log2 of finest grid side; finest level is 2^BOX_IDX x 2^BOX_IDX cells.
REQ-002 Parameter DATA_LEN, default 8, meaning box-count RAM word width.
REQ-003 CLK  input  1  clock; all state changes on rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  one-cycle scan request; sampled only in IDLE.
REQ-006 level  input  BOX_IDX+1  grid level; grid side = 2^(BOX_IDX-level); sampled with start.
REQ-007 bank  input  1  RAM half to read; sampled with start.
REQ-008 rd_en  output  1  RAM read strobe.
REQ-009 rd_addr  output  2*BOX_IDX+1  RAM address, packed {x[BOX_IDX-1:0], bank, y[BOX_IDX-1:0]}.
REQ-010 rd_data  input  DATA_LEN  RAM read data, valid one cycle after the address (synchronous read, latency 1).
REQ-011 busy  output  1  high from the cycle after start is accepted until done.
REQ-012 done  output  1  one-cycle pulse: results valid.
REQ-013 box_cnt  output  2*BOX_IDX+1  number of cells with rd_data != 0.
REQ-014 mass_sum  output  DATA_LEN+2*BOX_IDX  sum of all cell values.
REQ-015 max_val  output  DATA_LEN  largest cell value.

Function
REQ-016 FSM states IDLE, SCAN, DRAIN, DONE; IDLE->SCAN on start; SCAN->DRAIN after the last address is issued; DRAIN->DONE; DONE->IDLE unconditionally.
REQ-017 The start cycle is T; level and bank are latched at the T edge; N = side^2 addresses are issued in cycles T+1..T+N with rd_en=1.
REQ-018 Scan order: x outer, y inner, both from 0 to side-1; unused upper coordinate bits are 0.
REQ-019 rd_data for the address issued in cycle k is accumulated at the end of cycle k+1; DRAIN (T+N+1) captures the last word.
REQ-020 done=1 in cycle T+N+2 only; box_cnt, mass_sum and max_val are updated at the same edge and held until the next accepted start.
REQ-021 Accumulators clear at start acceptance; box_cnt increments when rd_data != 0; mass_sum adds zero-extended rd_data; max_val is the unsigned maximum.
REQ-022 Widths cover worst case (2^(2*BOX_IDX) cells x (2^DATA_LEN-1)); no saturation or wrap is required.
REQ-023 level > BOX_IDX is clamped to BOX_IDX (1 cell, address {0,bank,0}).
REQ-024 start outside IDLE (SCAN, DRAIN, DONE) is ignored with no effect on the running scan.
REQ-025 rd_en=0 and rd_addr holds its last value outside SCAN.
REQ-026 busy=1 in SCAN and DRAIN; busy=0 in IDLE and DONE.

Reset
REQ-027 RST asserted forces IDLE immediately, aborting any scan, and sets rd_en, busy, done = 0, rd_addr = 0, box_cnt = 0, mass_sum = 0, max_val = 0.
REQ-028 After RST deasserts, the first start is accepted normally.

Verification
REQ-029 BOX_IDX=3, level=0, bank=0, all cells = 1, start at T -> 64 reads in T+1..T+64, done at T+66, box_cnt=64, mass_sum=64, max_val=1.
REQ-030 level=2, bank=1 -> rd_addr sequence 8, 9, 24, 25; done at T+6; with data 3,0,7,2: box_cnt=3, mass_sum=12, max_val=7.
REQ-031 level=0, all cells = 255 -> mass_sum=16320, box_cnt=64, max_val=255.
REQ-032 level=0, all cells = 0 -> box_cnt=0, mass_sum=0, max_val=0; then level=5 -> single read at address 0, done at T+3.
REQ-033 Second start pulsed at T+10 during a level-0 scan -> ignored; exactly one done, at T+66.
REQ-034 RST at T+20 during a scan -> all outputs 0 next cycle and no done pulse; a new start with level=3 completes with done at T'+3.

Source files
------------

// File: rtl/bc_scan.sv
// Box-count scanner: walks one square grid level of a box-count RAM bank and
// reports the non-zero cell count, the value sum and the peak value.
module bc_scan #(
    parameter int BOX_IDX  = 3,
    parameter int DATA_LEN = 8
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         start,
    input  logic [BOX_IDX:0]             level,
    input  logic                         bank,
    output logic                         rd_en,
    output logic [2*BOX_IDX:0]           rd_addr,
    input  logic [DATA_LEN-1:0]          rd_data,
    output logic                         busy,
    output logic                         done,
    output logic [2*BOX_IDX:0]           box_cnt,
    output logic [DATA_LEN+2*BOX_IDX-1:0] mass_sum,
    output logic [DATA_LEN-1:0]          max_val
);

    localparam int AW = 2*BOX_IDX + 1;
    localparam int SW = DATA_LEN + 2*BOX_IDX;
    localparam logic [BOX_IDX:0]   LVL_MAX  = (BOX_IDX+1)'(BOX_IDX);
    localparam logic [BOX_IDX-1:0] C_ZERO   = {BOX_IDX{1'b0}};
    localparam logic [BOX_IDX-1:0] C_ONES   = {BOX_IDX{1'b1}};
    localparam logic [BOX_IDX-1:0] C_ONE    = {{(BOX_IDX-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [BOX_IDX-1:0]    r_x;
    logic [BOX_IDX-1:0]    r_y;
    logic [BOX_IDX-1:0]    r_max_coord;
    logic                  r_bank;
    logic                  r_rd_en;
    logic [AW-1:0]         r_rd_addr;
    logic                  r_vld;
    logic                  r_busy;
    logic                  r_done;
    logic [AW-1:0]         r_acc_cnt;
    logic [SW-1:0]         r_acc_sum;
    logic [DATA_LEN-1:0]   r_acc_max;
    logic [AW-1:0]         r_box_cnt;
    logic [SW-1:0]         r_mass_sum;
    logic [DATA_LEN-1:0]   r_max_val;

    logic [BOX_IDX:0]      w_lvl;
    logic [BOX_IDX-1:0]    w_max_coord;
    logic                  w_last;
    logic                  w_nz;
    logic [AW-1:0]         w_cnt_nxt;
    logic [SW-1:0]         w_sum_nxt;
    logic [DATA_LEN-1:0]   w_max_nxt;

    // Level clamp, last-address detect and accumulator next values.
    always_comb begin
        w_lvl       = level;
        w_max_coord = C_ZERO;
        w_last      = 1'b0;
        w_nz        = 1'b0;
        w_cnt_nxt   = r_acc_cnt;
        w_sum_nxt   = r_acc_sum;
        w_max_nxt   = r_acc_max;
        if (level > LVL_MAX) begin
            w_lvl = LVL_MAX;
        end else begin
            w_lvl = level;
        end
        // The grid side minus one is the all-ones coordinate shifted down by the level.
        w_max_coord = C_ONES >> w_lvl;
        w_last      = (r_x == r_max_coord) && (r_y == r_max_coord);
        w_nz        = (rd_data != {DATA_LEN{1'b0}});
        w_cnt_nxt   = r_acc_cnt + {{(AW-1){1'b0}}, w_nz};
        w_sum_nxt   = r_acc_sum + {{(2*BOX_IDX){1'b0}}, rd_data};
        if (rd_data > r_acc_max) begin
            w_max_nxt = rd_data;
        end else begin
            w_max_nxt = r_acc_max;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  begin
                if (start) begin
                    w_state_nxt = ST_SCAN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SCAN:  begin
                if (w_last) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_SCAN;
                end
            end
            ST_DRAIN: w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Address walk, accumulation and result capture.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_x         <= C_ZERO;
            r_y         <= C_ZERO;
            r_max_coord <= C_ZERO;
            r_bank      <= 1'b0;
            r_rd_en     <= 1'b0;
            r_rd_addr   <= {AW{1'b0}};
            r_vld       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_acc_cnt   <= {AW{1'b0}};
            r_acc_sum   <= {SW{1'b0}};
            r_acc_max   <= {DATA_LEN{1'b0}};
            r_box_cnt   <= {AW{1'b0}};
            r_mass_sum  <= {SW{1'b0}};
            r_max_val   <= {DATA_LEN{1'b0}};
        end else begin
            // Read data lags the strobe by one cycle.
            r_vld <= r_rd_en;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_max_coord <= w_max_coord;
                        r_bank      <= bank;
                        r_x         <= C_ZERO;
                        r_y         <= C_ZERO;
                        r_rd_en     <= 1'b1;
                        r_rd_addr   <= {C_ZERO, bank, C_ZERO};
                        r_busy      <= 1'b1;
                        r_acc_cnt   <= {AW{1'b0}};
                        r_acc_sum   <= {SW{1'b0}};
                        r_acc_max   <= {DATA_LEN{1'b0}};
                    end
                end
                ST_SCAN: begin
                    if (r_vld) begin
                        r_acc_cnt <= w_cnt_nxt;
                        r_acc_sum <= w_sum_nxt;
                        r_acc_max <= w_max_nxt;
                    end
                    if (w_last) begin
                        r_rd_en <= 1'b0;
                    end else if (r_y == r_max_coord) begin
                        r_y       <= C_ZERO;
                        r_x       <= r_x + C_ONE;
                        r_rd_addr <= {r_x + C_ONE, r_bank, C_ZERO};
                    end else begin
                        r_y       <= r_y + C_ONE;
                        r_rd_addr <= {r_x, r_bank, r_y + C_ONE};
                    end
                end
                ST_DRAIN: begin
                    r_box_cnt  <= w_cnt_nxt;
                    r_mass_sum <= w_sum_nxt;
                    r_max_val  <= w_max_nxt;
                    r_done     <= 1'b1;
                    r_busy     <= 1'b0;
                end
                ST_DONE: begin
                    r_done <= 1'b0;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_rd_en <= 1'b0;
                end
            endcase
        end
    end

    assign rd_en    = r_rd_en;
    assign rd_addr  = r_rd_addr;
    assign busy     = r_busy;
    assign done     = r_done;
    assign box_cnt  = r_box_cnt;
    assign mass_sum = r_mass_sum;
    assign max_val  = r_max_val;

endmodule
